// File: rtl/rcc_rtc_pkg.sv
// Shared types and helpers for the RTC ratio sequencer and the HSE->RTC divider wrapper.
package rcc_rtc_pkg;

  localparam int unsigned RTC_SETTLE_CYC_DEF = 8;
  localparam int unsigned RTC_CNT_WID        = 8;
  localparam int unsigned RTC_RATIO_MAX_WID  = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE     = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_APPLY    = 2'd3
  } rtc_state_e;

  // Ratios 0 and 1 both leave the divider disabled.
  function automatic logic rtc_ratio_active(input logic [RTC_RATIO_MAX_WID-1:0] ratio);
    return |ratio[RTC_RATIO_MAX_WID-1:1];
  endfunction

endpackage

// File: rtl/rcc_settle_cnt.sv
// Loadable down-counter that holds at zero; done is high while the count is zero.
module rcc_settle_cnt
  import rcc_rtc_pkg::*;
#(
  parameter int unsigned CNT_W = RTC_CNT_WID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/rcc_rtc_ratio_ctrl.sv
// RTC prescaler ratio sequencer: every ratio change passes through a gated (ratio 0) phase.
// Optional HSE-loss auto-off behaviour is enabled with `define RCC_RTC_RATIO_AUTOOFF_EN.
module rcc_rtc_ratio_ctrl
  import rcc_rtc_pkg::*;
#(
  parameter int unsigned RATIO_WID  = 6,
  parameter int unsigned SETTLE_CYC = RTC_SETTLE_CYC_DEF
) (
  input  logic                 i_clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [RATIO_WID-1:0] wr_ratio,
  input  logic                 hse_rdy,
  output logic [RATIO_WID-1:0] ratio_o,
  output logic [RATIO_WID-1:0] cur_ratio,
  output logic                 busy,
  output logic                 wr_err,
  output logic                 hse_lost
);

`ifdef RCC_RTC_RATIO_AUTOOFF_EN
  localparam bit AUTOOFF = 1'b1;
`else
  localparam bit AUTOOFF = 1'b0;
`endif

  localparam logic [RTC_CNT_WID-1:0] LOAD_VAL = RTC_CNT_WID'(SETTLE_CYC - 1);

  rtc_state_e           state_q, state_d;
  logic [RATIO_WID-1:0] cur_d, ratio_d;
  logic                 busy_d, err_d, lost_d;
  logic                 cnt_load, cnt_done;
  logic                 hse_low_q, auto_trip;
  logic                 cur_act, wr_act, nxt_act;

  rcc_settle_cnt #(
    .CNT_W (RTC_CNT_WID)
  ) u_settle_cnt (
    .clk      (i_clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .done     (cnt_done)
  );

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_ratio <= '0;
      ratio_o   <= '0;
      busy      <= 1'b0;
      wr_err    <= 1'b0;
      hse_lost  <= 1'b0;
      hse_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ratio <= cur_d;
      ratio_o   <= ratio_d;
      busy      <= busy_d;
      wr_err    <= err_d;
      hse_lost  <= AUTOOFF & lost_d;
      hse_low_q <= ~hse_rdy;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_ratio;
    lost_d    = hse_lost;
    err_d     = 1'b0;
    cnt_load  = 1'b0;
    ratio_d   = '0;
    busy_d    = 1'b0;
    cur_act   = rtc_ratio_active(RTC_RATIO_MAX_WID'(cur_ratio));
    wr_act    = rtc_ratio_active(RTC_RATIO_MAX_WID'(wr_ratio));
    auto_trip = AUTOOFF & ~hse_rdy & hse_low_q;

    case (state_q)
      ST_IDLE: begin
        if (auto_trip && cur_act) begin
          state_d  = ST_GATE;
          cur_d    = '0;
          lost_d   = 1'b1;
          cnt_load = 1'b1;
        end else if (wr_en && (wr_ratio != cur_ratio)) begin
          cur_d  = wr_ratio;
          lost_d = 1'b0;
          if (cur_act) begin
            state_d  = ST_GATE;
            cnt_load = 1'b1;
          end else if (wr_act) begin
            state_d = ST_WAIT_RDY;
          end
        end
      end
      ST_GATE: begin
        err_d = wr_en;
        if (cnt_done) begin
          state_d = cur_act ? ST_WAIT_RDY : ST_IDLE;
        end
      end
      ST_WAIT_RDY: begin
        // A write here retargets; it takes priority over hse_rdy in the same cycle.
        if (wr_en) begin
          cur_d  = wr_ratio;
          lost_d = 1'b0;
          if (!wr_act) begin
            state_d = ST_IDLE;
          end
        end else if (hse_rdy) begin
          state_d  = ST_APPLY;
          cnt_load = 1'b1;
        end
      end
      ST_APPLY: begin
        err_d = wr_en;
        if (auto_trip) begin
          state_d  = ST_GATE;
          cur_d    = '0;
          lost_d   = 1'b1;
          cnt_load = 1'b1;
        end else if (cnt_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    nxt_act = rtc_ratio_active(RTC_RATIO_MAX_WID'(cur_d));
    case (state_d)
      ST_IDLE:  ratio_d = nxt_act ? cur_d : '0;
      ST_APPLY: ratio_d = cur_d;
      default:  ratio_d = '0;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule
